// File: rtl/se_channel_scaler.sv
// Squeeze-and-Excite channel scaler: latches one per-channel scale vector, then
// streams IN_HEIGHT*IN_WIDTH pixel beats, multiplying each channel by its scale.
module se_channel_scaler #(
  parameter int IN_SIZE    = 16,
  parameter int IN_HEIGHT  = 56,
  parameter int IN_WIDTH   = 56,
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         scale_valid,
  input  logic signed [DATA_WIDTH-1:0] scale_in [0:IN_SIZE-1],
  output logic                         scale_ready,
  input  logic                         pix_valid,
  input  logic signed [DATA_WIDTH-1:0] pix_in [0:IN_SIZE-1],
  output logic                         pix_ready,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data [0:IN_SIZE-1],
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int N_PIX = IN_HEIGHT * IN_WIDTH;
  localparam int CNT_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PIX - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                       r_state;
  logic [CNT_W-1:0]             r_cnt;
  logic signed [DATA_WIDTH-1:0] r_scale    [0:IN_SIZE-1];
  logic signed [DATA_WIDTH-1:0] r_out_data [0:IN_SIZE-1];
  logic                         r_out_valid;
  logic                         r_out_last;

  logic                         w_pix_xfer;
  logic                         w_out_xfer;
  logic                         w_is_last;
  logic signed [DATA_WIDTH-1:0] w_scaled [0:IN_SIZE-1];

  // Full-precision product, arithmetic shift (floor), then clamp to DATA_WIDTH.
  function automatic logic signed [DATA_WIDTH-1:0] scale_sat(
    input logic signed [DATA_WIDTH-1:0] pix,
    input logic signed [DATA_WIDTH-1:0] scl
  );
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [2*DATA_WIDTH-1:0] shifted;
    prod    = (2*DATA_WIDTH)'(pix) * (2*DATA_WIDTH)'(scl);
    shifted = prod >>> FRAC_BITS;
    if (shifted[2*DATA_WIDTH-1:DATA_WIDTH-1] == {(DATA_WIDTH+1){shifted[2*DATA_WIDTH-1]}})
      return shifted[DATA_WIDTH-1:0];
    else if (shifted[2*DATA_WIDTH-1])
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  assign scale_ready = (r_state == S_IDLE);
  assign pix_ready   = (r_state == S_STREAM) && (!r_out_valid || out_ready);
  assign w_pix_xfer  = pix_valid && pix_ready;
  assign w_out_xfer  = r_out_valid && out_ready;
  assign w_is_last   = (r_cnt == CNT_LAST);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state == S_STREAM) || r_out_valid;

  always_comb begin
    for (int c = 0; c < IN_SIZE; c++)
      w_scaled[c] = scale_sat(pix_in[c], r_scale[c]);
  end

  // Control: frame state and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_scale <= '{default: '0};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (scale_valid) begin
            r_scale <= scale_in;
            r_cnt   <= '0;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_pix_xfer) begin
            if (w_is_last) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output register: a new beat takes priority over draining the current one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '{default: '0};
    end else if (w_pix_xfer) begin
      r_out_data  <= w_scaled;
      r_out_valid <= 1'b1;
      r_out_last  <= w_is_last;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_se_channel_scaler.sv
// Directed bench for se_channel_scaler: 4 channels, 2x2 frame, Q4.4 scales.
module tb_se_channel_scaler;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 scale_valid = 1'b0;
  logic signed [DW-1:0] scale_in [0:NCH-1];
  logic                 scale_ready;
  logic                 pix_valid = 1'b0;
  logic signed [DW-1:0] pix_in [0:NCH-1];
  logic                 pix_ready;
  logic                 out_valid;
  logic signed [DW-1:0] out_data [0:NCH-1];
  logic                 out_last;
  logic                 out_ready = 1'b1;
  logic                 busy;

  int n_vec = 0;
  int n_err = 0;
  int n_beats = 0;
  int base = 0;
  logic [31:0] w_out_flat;

  localparam logic [31:0] F1 [4] = '{32'h2001F07F, 32'h01F07F20, 32'hF07F2001, 32'h7F2001F0};
  localparam logic [31:0] F2 [4] = '{32'hFD074080, 32'h07FD8001, 32'h00017F40, 32'hFF1002FF};
  localparam logic [31:0] E2 [4] = '{32'hFE037F7F, 32'h03FE80F8, 32'h00007F80, 32'hFF080F08};
  localparam logic [31:0] F3 [2] = '{32'h10101010, 32'hFF050FF3};
  localparam logic [31:0] E3 [2] = '{32'h20F00110, 32'hFEFB00F3};
  localparam logic [31:0] F4 [4] = '{32'h01010101, 32'h05F820F7, 32'h2BE0E07F, 32'hD6020081};
  localparam logic [31:0] E4 [4] = '{32'h03FC0400, 32'h0F207FFB, 32'h7F7F803F, 32'h82F800C0};

  se_channel_scaler #(
    .IN_SIZE(NCH), .IN_HEIGHT(2), .IN_WIDTH(2), .DATA_WIDTH(DW), .FRAC_BITS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .scale_valid(scale_valid), .scale_in(scale_in), .scale_ready(scale_ready),
    .pix_valid(pix_valid), .pix_in(pix_in), .pix_ready(pix_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    w_out_flat = '0;
    for (int c = 0; c < NCH; c++)
      w_out_flat[31-8*c -: 8] = out_data[c];
  end

  always @(posedge clk)
    if (out_valid && out_ready) n_beats <= n_beats + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic [31:0] v);
    for (int c = 0; c < NCH; c++) pix_in[c] = v[31-8*c -: 8];
  endtask

  task automatic set_scale(input logic [31:0] v);
    for (int c = 0; c < NCH; c++) scale_in[c] = v[31-8*c -: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    set_pix(32'h0);
    set_scale(32'h0);
    rst = 1'b1;
    #12;
    rst = 1'b0;
    #1;
    chk("rst_scale_ready", 32'(scale_ready), 32'd1);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", w_out_flat, 32'h0);
    tick();

    // Frame 1: unity scale, full throughput
    base = n_beats;
    set_scale(32'h10101010);
    scale_valid = 1'b1;
    tick();
    scale_valid = 1'b0;
    chk("f1_scale_ready", 32'(scale_ready), 32'd0);
    chk("f1_busy", 32'(busy), 32'd1);
    chk("f1_pix_ready", 32'(pix_ready), 32'd1);
    pix_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_pix(F1[k]);
      tick();
      chk("f1_valid", 32'(out_valid), 32'd1);
      chk("f1_data", w_out_flat, F1[k]);
      chk("f1_last", 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
    end
    pix_valid = 1'b0;
    chk("f1_idle_scale_ready", 32'(scale_ready), 32'd1);
    tick();
    chk("f1_drained", 32'(out_valid), 32'd0);
    chk("f1_busy_end", 32'(busy), 32'd0);
    chk("f1_beats", 32'(n_beats - base), 32'd4);

    // Pixels offered in IDLE are not consumed
    pix_valid = 1'b1;
    set_pix(32'h11223344);
    chk("idle_pix_ready", 32'(pix_ready), 32'd0);
    tick();
    chk("idle_no_out", 32'(out_valid), 32'd0);
    tick();
    chk("idle_no_out2", 32'(out_valid), 32'd0);
    pix_valid = 1'b0;

    // Frame 2: fractional, negative and saturating scales with backpressure
    base = n_beats;
    set_scale(32'h08087F80);
    scale_valid = 1'b1;
    tick();
    scale_valid = 1'b0;
    pix_valid = 1'b1;
    set_pix(F2[0]);
    tick();
    chk("f2_b0", w_out_flat, E2[0]);
    out_ready = 1'b0;
    set_pix(F2[1]);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_data", w_out_flat, E2[0]);
      chk("bp_hold_last", 32'(out_last), 32'd0);
      chk("bp_pix_ready", 32'(pix_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("f2_b1", w_out_flat, E2[1]);
    set_pix(F2[2]);
    set_scale(32'h10101010);
    scale_valid = 1'b1;
    tick();
    scale_valid = 1'b0;
    chk("f2_b2", w_out_flat, E2[2]);
    set_pix(F2[3]);
    tick();
    chk("f2_b3_oldscale", w_out_flat, E2[3]);
    chk("f2_b3_last", 32'(out_last), 32'd1);

    // Reload scale while the last beat is stalled
    out_ready = 1'b0;
    pix_valid = 1'b0;
    set_scale(32'h20F00110);
    scale_valid = 1'b1;
    tick();
    scale_valid = 1'b0;
    chk("reload_held_data", w_out_flat, E2[3]);
    chk("reload_held_last", 32'(out_last), 32'd1);
    chk("reload_scale_ready", 32'(scale_ready), 32'd0);
    chk("reload_pix_ready", 32'(pix_ready), 32'd0);
    pix_valid = 1'b1;
    set_pix(F3[0]);
    tick();
    chk("reload_wait_data", w_out_flat, E2[3]);
    out_ready = 1'b1;
    tick();
    chk("f3_b0", w_out_flat, E3[0]);
    chk("f3_b0_last", 32'(out_last), 32'd0);
    chk("f2_beats", 32'(n_beats - base), 32'd4);
    set_pix(F3[1]);
    tick();
    chk("f3_b1", w_out_flat, E3[1]);
    pix_valid = 1'b0;

    // Asynchronous reset mid-frame
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_scale_ready", 32'(scale_ready), 32'd1);
    chk("mid_rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("mid_rst_data", w_out_flat, 32'h0);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    // Frame 4: new scale after reset
    base = n_beats;
    set_scale(32'h30C04008);
    scale_valid = 1'b1;
    tick();
    scale_valid = 1'b0;
    pix_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_pix(F4[k]);
      tick();
      chk("f4_data", w_out_flat, E4[k]);
      chk("f4_last", 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
    end
    pix_valid = 1'b0;
    tick();
    chk("f4_drained", 32'(out_valid), 32'd0);
    chk("f4_beats", 32'(n_beats - base), 32'd4);
    chk("f4_scale_ready", 32'(scale_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
